prog_loader: RTL

- Upstream boot stage for the pipelined RISC-V core.
- Receives a program as a byte stream and packs it big-endian into 32-bit words.
- Writes each word into the core's instruction/data memory, starting at word address 0.
- Holds the core in halt until the program's HALT word (default 0xfc000000) has been written, then releases it with a start pulse. This replaces manual memory preload plus HALTED/PC/TAKEN_BRANCH initialisation.

---
 rtl/prog_loader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot loader for the pipelined RISC-V core: byte stream -> big-endian
// 32-bit words -> instruction/data memory from word 0 upward. The core is
// held until the HALT word has been written, then released with a
// one-cycle start pulse.
//
// Optional build macro: PROG_LOADER_CHECKSUM_EN
//   When defined, the HALT word is followed by one checksum byte that must
//   equal the XOR of every load byte (HALT word included) before the core
//   is released.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, core held, stream not ready
// LOAD   | accepting bytes, writing one word per 4 bytes
// CHK    | (checksum build only) waiting for the checksum byte
// DONE   | program loaded, core released (start pulse on first cycle)
// ERR    | overflow, timeout or bad checksum; core held, flag raised

module prog_loader #(
   parameter int          ADDR_W    = 10,
   parameter int          MEM_DEPTH = 1024,
   parameter logic [31:0] HALT_WORD = 32'hfc000000,
   parameter int          TIMEOUT   = 4096
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              core_start,
   output logic [ADDR_W:0]   word_count,
   output logic              load_err
);

   localparam int              TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
   localparam logic [ADDR_W:0]  LAST_CNT = (ADDR_W + 1)'(MEM_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_DONE = 3'd2,
      S_ERR  = 3'd3
`ifdef PROG_LOADER_CHECKSUM_EN
      ,
      S_CHK  = 3'd4
`endif
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [1:0]        byte_idx_q;
   logic [23:0]       shreg_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   count_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [TMR_W-1:0]  tmr_q;
   logic              done_seen_q;

   logic              hs;
   logic              halt_wr;
   logic              full_wr;
   logic              tmr_tc;
   logic              tmr_run;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        xor_q;
`endif

   // The write cycle that carries the HALT word (or the last writable word)
   // closes the stream in that same cycle so no trailing byte is swallowed.
   assign halt_wr = we_q && (wdata_q == HALT_WORD);
   assign full_wr = we_q && (count_q == LAST_CNT);
   assign tmr_tc  = (tmr_q == '0);
   assign hs      = in_valid && in_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
   assign tmr_run = (state_q == S_LOAD) || (state_q == S_CHK);
`else
   assign tmr_run = (state_q == S_LOAD);
`endif

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign word_count = count_q;
   assign core_hold  = (state_q != S_DONE);
   assign core_start = (state_q == S_DONE) && !done_seen_q;
   assign load_err   = (state_q == S_ERR);

   // Stream ready; load_start wins over a byte offered in the same cycle.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         S_LOAD:  in_ready = !(halt_wr || full_wr) && !load_start;
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CHK:   in_ready = !load_start;
`endif
         default: in_ready = 1'b0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (load_start) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (load_start) begin
               state_d = S_LOAD;
            end else if (halt_wr) begin
`ifdef PROG_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_DONE;
`endif
            end else if (full_wr) begin
               state_d = S_ERR;
            end else if (!hs && tmr_tc) begin
               state_d = S_ERR;
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (load_start) begin
               state_d = S_LOAD;
            end else if (hs) begin
               state_d = (in_data == xor_q) ? S_DONE : S_ERR;
            end else if (tmr_tc) begin
               state_d = S_ERR;
            end
         end
`endif
         S_DONE: begin
            if (load_start) state_d = S_LOAD;
         end
         S_ERR: begin
            if (load_start) state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register plus the flag that limits core_start to one cycle.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         done_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_seen_q <= (state_q == S_DONE);
      end
   end

   // Byte packing, word write, address/count and idle timer.
   // The 4th byte lands the word in wdata_q while shreg_q is free to start
   // the next word, so the stream never stalls for the write.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx_q <= '0;
         shreg_q    <= '0;
         addr_q     <= '0;
         count_q    <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         tmr_q      <= '0;
      end else if (load_start) begin
         byte_idx_q <= '0;
         shreg_q    <= '0;
         addr_q     <= '0;
         count_q    <= '0;
         we_q       <= 1'b0;
         tmr_q      <= TMR_LOAD;
      end else begin
         we_q <= 1'b0;
         if (we_q) begin
            addr_q  <= addr_q + 1'b1;
            count_q <= count_q + 1'b1;
         end
         if (hs) begin
            tmr_q <= TMR_LOAD;
            if (state_q == S_LOAD) begin
               shreg_q    <= {shreg_q[15:0], in_data};
               byte_idx_q <= byte_idx_q + 1'b1;
               if (byte_idx_q == 2'd3) begin
                  we_q    <= 1'b1;
                  wdata_q <= {shreg_q, in_data};
               end
            end
         end else if (tmr_run && !tmr_tc) begin
            tmr_q <= tmr_q - 1'b1;
         end
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   // Running XOR of every byte accepted while loading.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         xor_q <= '0;
      end else if (load_start) begin
         xor_q <= '0;
      end else if (hs && (state_q == S_LOAD)) begin
         xor_q <= xor_q ^ in_data;
      end
   end
`endif

endmodule
